dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single data memory (datamem) between the CPU load/store unit (port 0) and a debug/loader master (port 1).
- Grants one request per cycle, round-robin with an optional lock for back-to-back bursts.
- Routes the one-cycle-latency read data back to whichever port issued the read.
- Sits between the core and datamem; lets the bench or debug logic preload and inspect data memory without stalling the design permanently.

Parameters:
ADDR_W, 32, byte-address width forwarded to memory
DATA_W, 32, data width (must be 32; byte enables are DATA_W/8)
LOCK_MAX, 8, maximum consecutive grants a locking port may hold before forced hand-over (1..255)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
m0_req_i  in  1  port 0 request valid
m0_we_i  in  1  port 0 write enable (1 = store)
m0_lock_i  in  1  port 0 requests to keep grant next cycle
m0_addr_i  in  ADDR_W  port 0 address
m0_wdata_i  in  DATA_W  port 0 write data
m0_be_i  in  DATA_W/8  port 0 byte enables
m0_gnt_o  out  1  port 0 request accepted this cycle
m0_rvalid_o  out  1  port 0 read data valid
m0_rdata_o  out  DATA_W  port 0 read data
m1_* (req_i, we_i, lock_i, addr_i, wdata_i, be_i, gnt_o, rvalid_o, rdata_o)  same widths and meanings, port 1
mem_req_o  out  1  memory access strobe
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_be_o  out  DATA_W/8  memory byte enables
mem_rdata_i  in  DATA_W  memory read data, valid one cycle after a read strobe

Behaviour:
- Reset (rst_ni low, asynchronous):
  - last_q = 1, so port 0 wins the first tie.
  - lock_owner_q = none, lock_cnt_q = 0, resp_q = none.
  - All rvalid_o = 0, all rdata_o = 0.
  - All gnt_o and mem_req_o forced 0 while reset is asserted.
- Grant is combinational in the request cycle. A request is accepted when req_i = 1 and gnt_o = 1 in the same cycle. There is no stall: a requester not granted must hold req and its fields stable.
- Arbitration order:
  1. If lock_owner_q is valid, its req_i is high and lock_cnt_q < LOCK_MAX, the owner wins.
  2. Otherwise, with a single requester, that requester wins.
  3. Otherwise, with both requesting, the port != last_q wins.
- At most one gnt_o is high per cycle. mem_req_o = OR of gnt_o; mem_* fields are muxed from the winner.
- On each grant edge:
  - last_q <= winner.
  - If winner lock_i = 1: lock_owner_q <= winner, lock_cnt_q <= lock_cnt_q + 1 if the owner is unchanged, else 1.
  - Else lock_owner_q <= none, lock_cnt_q <= 0.
  - No grant: lock state is unchanged.
- Lock_cnt overflow: when lock_cnt_q reaches LOCK_MAX and the other port is requesting, the other port is granted and lock state clears. If the other port is idle, the owner continues and the count saturates at LOCK_MAX.
- Response path:
  - resp_q <= winner if the granted access is a read, else none.
  - Next cycle, the port equal to resp_q gets rvalid_o = 1 and rdata_o = mem_rdata_i. The other port's rvalid_o = 0.
  - rdata_o holds its last value when rvalid_o = 0.
- Writes produce no rvalid.
- Back-to-back reads from alternating ports are allowed. Responses return in grant order, one per cycle.
- Reset mid-operation: a pending response is discarded (no rvalid after reset release) and lock state clears.
- Ports whose req_i = 0 ignore all other inputs.

Test Plan:
- Lone read: m0 reads addr 0x10 holding 0xDEADBEEF → m0_gnt_o = 1 in the same cycle, m0_rvalid_o = 1 with rdata 0xDEADBEEF on the next cycle, m1_rvalid_o stays 0.
- Tie after reset: both request in the same cycle for 4 cycles → grants alternate 0, 1, 0, 1; each read response appears one cycle later on the matching port.
- Lock with LOCK_MAX = 3: m1 holds lock_i = 1 and req while m0 also requests → m1 granted 3 consecutive cycles, m0 on the 4th, then m1.
- Write then read: m1 writes 0x00000055 with be = 0001 to 0x20, then m0 reads 0x20 → no rvalid for the write; m0 receives the memory-model value with byte 0 = 0x55.
- Reset mid-read: m0 read granted, rst_ni pulsed low before the next edge → no m0_rvalid_o after release, last_q = 1, and the next tie goes to m0.
- Idle lock owner: m0 lock_i = 1 for 12 cycles with m1 idle → m0 granted all 12 cycles, lock_cnt saturates at 8.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the shared data memory port.
// The arbiter takes the slave side; the core/bench drives the master side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              m0_req_i;
    logic              m0_we_i;
    logic              m0_lock_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_wdata_i;
    logic [BE_W-1:0]   m0_be_i;
    logic              m0_gnt_o;
    logic              m0_rvalid_o;
    logic [DATA_W-1:0] m0_rdata_o;

    logic              m1_req_i;
    logic              m1_we_i;
    logic              m1_lock_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_wdata_i;
    logic [BE_W-1:0]   m1_be_i;
    logic              m1_gnt_o;
    logic              m1_rvalid_o;
    logic [DATA_W-1:0] m1_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  m0_req_i, m0_we_i, m0_lock_i,
        input  m0_addr_i, m0_wdata_i, m0_be_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        input  m1_req_i, m1_we_i, m1_lock_i,
        input  m1_addr_i, m1_wdata_i, m1_be_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o,
        output mem_wdata_o, mem_be_o,
        input  mem_rdata_i
    );

    modport master (
        output m0_req_i, m0_we_i, m0_lock_i,
        output m0_addr_i, m0_wdata_i, m0_be_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        output m1_req_i, m1_we_i, m1_lock_i,
        output m1_addr_i, m1_wdata_i, m1_be_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o,
        input  mem_wdata_o, mem_be_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin data memory arbiter with burst lock.
// Port 0 = load/store unit, port 1 = debug/loader master.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    dmem_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [7:0] LMAX = 8'(LOCK_MAX);

    logic       r_last;
    logic       r_lock_vld;
    logic       r_lock_own;
    logic [7:0] r_lock_cnt;
    logic       r_resp_vld;
    logic       r_resp_port;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic [1:0]        w_req;
    logic              w_lock_win;
    logic              w_any;
    logic              w_win;
    logic              w_we;
    logic              w_lock;
    logic              w_rv0;
    logic              w_rv1;

    assign w_req = {bus.m1_req_i, bus.m0_req_i};

    // The lock owner keeps the bus only while it still asks and has quota left.
    assign w_lock_win = r_lock_vld && w_req[r_lock_own]
                      && (r_lock_cnt < LMAX);

    // Pick the winner: lock owner, lone requester, then alternate on ties.
    always_comb begin
        w_any = 1'b0;
        w_win = 1'b0;
        if (!rst_ni) begin
            w_any = 1'b0;
        end else if (w_lock_win) begin
            w_any = 1'b1;
            w_win = r_lock_own;
        end else if (w_req == 2'b01) begin
            w_any = 1'b1;
            w_win = 1'b0;
        end else if (w_req == 2'b10) begin
            w_any = 1'b1;
            w_win = 1'b1;
        end else if (w_req == 2'b11) begin
            w_any = 1'b1;
            w_win = ~r_last;
        end
    end

    assign w_we   = w_win ? bus.m1_we_i   : bus.m0_we_i;
    assign w_lock = w_win ? bus.m1_lock_i : bus.m0_lock_i;

    assign bus.m0_gnt_o   = w_any && !w_win;
    assign bus.m1_gnt_o   = w_any &&  w_win;
    assign bus.mem_req_o  = w_any;
    assign bus.mem_we_o   = w_we;
    assign bus.mem_addr_o = w_win ? bus.m1_addr_i : bus.m0_addr_i;
    assign bus.mem_wdata_o = w_win ? bus.m1_wdata_i : bus.m0_wdata_i;
    assign bus.mem_be_o   = w_win ? bus.m1_be_i : bus.m0_be_i;

    // Track the last winner and the burst lock owner/count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last     <= 1'b1;
            r_lock_vld <= 1'b0;
            r_lock_own <= 1'b0;
            r_lock_cnt <= 8'd0;
        end else if (w_any) begin
            r_last <= w_win;
            if (w_lock) begin
                r_lock_vld <= 1'b1;
                r_lock_own <= w_win;
                if (r_lock_vld && (r_lock_own == w_win)) begin
                    r_lock_cnt <= (r_lock_cnt >= LMAX) ? LMAX
                                : r_lock_cnt + 8'd1;
                end else begin
                    r_lock_cnt <= 8'd1;
                end
            end else begin
                r_lock_vld <= 1'b0;
                r_lock_cnt <= 8'd0;
            end
        end
    end

    // Remember which port owns the read data returning next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resp_vld  <= 1'b0;
            r_resp_port <= 1'b0;
        end else begin
            r_resp_vld  <= w_any && !w_we;
            r_resp_port <= w_win;
        end
    end

    assign w_rv0 = r_resp_vld && !r_resp_port;
    assign w_rv1 = r_resp_vld &&  r_resp_port;

    // Hold the last delivered read word per port between responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_rv0) r_rdata0 <= bus.mem_rdata_i;
            if (w_rv1) r_rdata1 <= bus.mem_rdata_i;
        end
    end

    assign bus.m0_rvalid_o = w_rv0;
    assign bus.m1_rvalid_o = w_rv1;
    assign bus.m0_rdata_o  = w_rv0 ? bus.mem_rdata_i : r_rdata0;
    assign bus.m1_rdata_o  = w_rv1 ? bus.mem_rdata_i : r_rdata1;

    logic [BE_W-1:0] w_unused_be;
    assign w_unused_be = '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-latency memory model.
// LOCK_MAX is set to 3 to exercise lock hand-over and saturation.
module tb_dmem_arbiter;
    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .LOCK_MAX(3)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [256];
    logic [31:0] mem_q;

    // Memory model: reloads known contents while reset is low.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + i;
            mem[4] <= 32'hDEAD_BEEF;
            mem[8] <= 32'h1122_3344;
            mem_q  <= 32'h0;
        end else if (bus.mem_req_o) begin
            if (bus.mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be_o[b])
                        mem[bus.mem_addr_o[9:2]][b*8 +: 8]
                            <= bus.mem_wdata_o[b*8 +: 8];
            end else begin
                mem_q <= mem[bus.mem_addr_o[9:2]];
            end
        end
    end
    assign bus.mem_rdata_i = mem_q;

    typedef struct {
        logic        req;
        logic        we;
        logic        lock;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } port_t;

    typedef struct {
        port_t       p0;
        port_t       p1;
        logic [1:0]  gnt;
        logic [1:0]  rv;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } vec_t;

    function automatic port_t f_idle();
        port_t p;
        p = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
        return p;
    endfunction

    function automatic port_t f_rd(input logic [31:0] a, input logic lk);
        port_t p;
        p = '{1'b1, 1'b0, lk, a, 32'h0, 4'hF};
        return p;
    endfunction

    function automatic port_t f_wr(input logic [31:0] a,
                                   input logic [31:0] d,
                                   input logic [3:0]  be,
                                   input logic        lk);
        port_t p;
        p = '{1'b1, 1'b1, lk, a, d, be};
        return p;
    endfunction

    task automatic drive(input port_t p0, input port_t p1);
        bus.m0_req_i   = p0.req;
        bus.m0_we_i    = p0.we;
        bus.m0_lock_i  = p0.lock;
        bus.m0_addr_i  = p0.addr;
        bus.m0_wdata_i = p0.wdata;
        bus.m0_be_i    = p0.be;
        bus.m1_req_i   = p1.req;
        bus.m1_we_i    = p1.we;
        bus.m1_lock_i  = p1.lock;
        bus.m1_addr_i  = p1.addr;
        bus.m1_wdata_i = p1.wdata;
        bus.m1_be_i    = p1.be;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    vec_t vt [17];
    port_t wl;
    port_t w0;

    initial begin
        n_run  = 0;
        n_fail = 0;
        wl = f_wr(32'h80, 32'hAAAA_0001, 4'hF, 1'b1);
        w0 = f_wr(32'h84, 32'hCAFE_0000, 4'hF, 1'b0);

        vt[0]  = '{f_rd(32'h04,0), f_rd(32'h08,0), 2'b01, 2'b00,
                   32'h0, 32'h0};
        vt[1]  = '{f_rd(32'h0C,0), f_rd(32'h08,0), 2'b10, 2'b01,
                   32'h1000_0001, 32'h0};
        vt[2]  = '{f_rd(32'h0C,0), f_rd(32'h14,0), 2'b01, 2'b10,
                   32'h1000_0001, 32'h1000_0002};
        vt[3]  = '{f_rd(32'h18,0), f_rd(32'h14,0), 2'b10, 2'b01,
                   32'h1000_0003, 32'h1000_0002};
        vt[4]  = '{f_idle(), f_idle(), 2'b00, 2'b10,
                   32'h1000_0003, 32'h1000_0005};
        vt[5]  = '{f_rd(32'h10,0), f_idle(), 2'b01, 2'b00,
                   32'h1000_0003, 32'h1000_0005};
        vt[6]  = '{f_idle(), f_idle(), 2'b00, 2'b01,
                   32'hDEAD_BEEF, 32'h1000_0005};
        vt[7]  = '{f_idle(), f_wr(32'h20, 32'h55, 4'b0001, 0),
                   2'b10, 2'b00, 32'hDEAD_BEEF, 32'h1000_0005};
        vt[8]  = '{f_rd(32'h20,0), f_idle(), 2'b01, 2'b00,
                   32'hDEAD_BEEF, 32'h1000_0005};
        vt[9]  = '{f_idle(), f_idle(), 2'b00, 2'b01,
                   32'h1122_3355, 32'h1000_0005};
        vt[10] = '{f_idle(), f_idle(), 2'b00, 2'b00,
                   32'h1122_3355, 32'h1000_0005};
        vt[11] = '{f_idle(), wl, 2'b10, 2'b00,
                   32'h1122_3355, 32'h1000_0005};
        vt[12] = '{w0, wl, 2'b10, 2'b00,
                   32'h1122_3355, 32'h1000_0005};
        vt[13] = '{w0, wl, 2'b10, 2'b00,
                   32'h1122_3355, 32'h1000_0005};
        vt[14] = '{w0, wl, 2'b01, 2'b00,
                   32'h1122_3355, 32'h1000_0005};
        vt[15] = '{w0, wl, 2'b10, 2'b00,
                   32'h1122_3355, 32'h1000_0005};
        vt[16] = '{f_idle(), f_idle(), 2'b00, 2'b00,
                   32'h1122_3355, 32'h1000_0005};

        // Reset with both ports requesting: nothing may be granted.
        rst_n = 1'b0;
        drive(f_rd(32'h04,0), f_rd(32'h08,0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst gnt", {30'd0, bus.m1_gnt_o, bus.m0_gnt_o}, 32'd0);
        chk("rst mem_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("rst rvalid",
            {30'd0, bus.m1_rvalid_o, bus.m0_rvalid_o}, 32'd0);
        chk("rst rdata0", bus.m0_rdata_o, 32'd0);
        chk("rst rdata1", bus.m1_rdata_o, 32'd0);
        drive(f_idle(), f_idle());
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            drive(vt[i].p0, vt[i].p1);
            @(negedge clk);
            chk($sformatf("v%0d gnt", i),
                {30'd0, bus.m1_gnt_o, bus.m0_gnt_o}, {30'd0, vt[i].gnt});
            chk($sformatf("v%0d rvalid", i),
                {30'd0, bus.m1_rvalid_o, bus.m0_rvalid_o},
                {30'd0, vt[i].rv});
            chk($sformatf("v%0d rdata0", i), bus.m0_rdata_o, vt[i].rd0);
            chk($sformatf("v%0d rdata1", i), bus.m1_rdata_o, vt[i].rd1);
        end

        // Reset pulse between a read grant and its response edge.
        @(posedge clk);
        #1;
        drive(f_rd(32'h10,0), f_idle());
        @(negedge clk);
        chk("mid gnt0", {31'd0, bus.m0_gnt_o}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid rst gnt0", {31'd0, bus.m0_gnt_o}, 32'd0);
        chk("mid rst mem_req", {31'd0, bus.mem_req_o}, 32'd0);
        drive(f_idle(), f_idle());
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid no rvalid0", {31'd0, bus.m0_rvalid_o}, 32'd0);
        chk("mid rdata0 cleared", bus.m0_rdata_o, 32'd0);
        @(posedge clk);
        #1;
        drive(f_rd(32'h04,0), f_rd(32'h08,0));
        @(negedge clk);
        chk("mid tie gnt",
            {30'd0, bus.m1_gnt_o, bus.m0_gnt_o}, 32'd1);

        // Lone locking owner keeps the bus; count saturates at LOCK_MAX.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            drive(f_rd(32'h10,1), f_idle());
            @(negedge clk);
            chk($sformatf("lk%0d gnt", i),
                {30'd0, bus.m1_gnt_o, bus.m0_gnt_o}, 32'd1);
            if (i > 0)
                chk($sformatf("lk%0d rdata0", i),
                    bus.m0_rdata_o, 32'hDEAD_BEEF);
        end
        chk("lk cnt sat", {24'd0, dut.r_lock_cnt}, 32'd3);
        @(posedge clk);
        #1;
        drive(f_rd(32'h10,1), f_rd(32'h08,0));
        @(negedge clk);
        chk("lk handover gnt",
            {30'd0, bus.m1_gnt_o, bus.m0_gnt_o}, 32'd2);
        @(posedge clk);
        #1;
        drive(f_idle(), f_idle());
        @(negedge clk);
        chk("lk handover rvalid1", {31'd0, bus.m1_rvalid_o}, 32'd1);
        chk("lk handover rdata1", bus.m1_rdata_o, 32'h1000_0002);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
